p22_spi_reg_writer: RTL

P22_SPI_REG_WRITER -- requirements
Module: p22_spi_reg_writer

---
 rtl/p22_spi_reg_writer_pkg.sv | 63 ++++++
 rtl/p22_spi_reg_writer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/p22_spi_reg_writer_pkg.sv
// Shared SPI register-write definitions, used by both the writer and the receiver.
// Contents:
//   CMD_*        command codes 0..10
//   LEN_*        payload length in bits for each command class
//   SPI_CMD_BITS width of the command field that leads every frame
//   spi_cmd_len  maps a command code to its payload length
//                (codes 11..15 carry a single payload bit)
//   spi_state_e  writer FSM states
package p22_spi_reg_writer_pkg;

  localparam int unsigned SPI_CMD_BITS = 4;
  localparam int unsigned SPI_MAX_LEN  = 24;
  localparam int unsigned SPI_MAX_BITS = SPI_CMD_BITS + SPI_MAX_LEN;

  localparam logic [3:0] CMD_SKY     = 4'd0;
  localparam logic [3:0] CMD_FLOOR   = 4'd1;
  localparam logic [3:0] CMD_LEAK    = 4'd2;
  localparam logic [3:0] CMD_OTHER   = 4'd3;
  localparam logic [3:0] CMD_VSHIFT  = 4'd4;
  localparam logic [3:0] CMD_VINF    = 4'd5;
  localparam logic [3:0] CMD_MAPD    = 4'd6;
  localparam logic [3:0] CMD_TEXADD0 = 4'd7;
  localparam logic [3:0] CMD_TEXADD1 = 4'd8;
  localparam logic [3:0] CMD_TEXADD2 = 4'd9;
  localparam logic [3:0] CMD_TEXADD3 = 4'd10;

  localparam logic [4:0] LEN_SKY    = 5'd6;
  localparam logic [4:0] LEN_FLOOR  = 5'd6;
  localparam logic [4:0] LEN_LEAK   = 5'd6;
  localparam logic [4:0] LEN_OTHER  = 5'd12;
  localparam logic [4:0] LEN_VSHIFT = 5'd6;
  localparam logic [4:0] LEN_VINF   = 5'd1;
  localparam logic [4:0] LEN_MAPD   = 5'd16;
  localparam logic [4:0] LEN_TEXADD = 5'd24;
  localparam logic [4:0] LEN_UNUSED = 5'd1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StGap
  } spi_state_e;

  function automatic logic [4:0] spi_cmd_len(input logic [3:0] code);
    logic [4:0] len;
    case (code)
      CMD_SKY:     len = LEN_SKY;
      CMD_FLOOR:   len = LEN_FLOOR;
      CMD_LEAK:    len = LEN_LEAK;
      CMD_OTHER:   len = LEN_OTHER;
      CMD_VSHIFT:  len = LEN_VSHIFT;
      CMD_VINF:    len = LEN_VINF;
      CMD_MAPD:    len = LEN_MAPD;
      CMD_TEXADD0,
      CMD_TEXADD1,
      CMD_TEXADD2,
      CMD_TEXADD3: len = LEN_TEXADD;
      default:     len = LEN_UNUSED;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/p22_spi_reg_writer.sv
// SPI mode-0 register writer. Accepts one command/payload per handshake and
// shifts out a frame of 4 command bits followed by the low LEN(cmd) payload
// bits, MSB first, then holds slave select high for SS_GAP clocks.
// Parameters:
//   SCLK_HALF  system clocks per SCLK half-period (>= 3)
//   SS_GAP     system clocks SS_n stays high between frames (>= 4)
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset (aborts any frame in flight)
//   cmd_valid  request to send a frame
//   cmd_ready  high only in IDLE; frame accepted on cmd_valid && cmd_ready
//   cmd        4-bit command code
//   payload    24-bit right-justified data
//   o_sclk     SPI clock, idles low
//   o_ss_n     active-low slave select
//   o_mosi     serial data out
//   done       one-cycle pulse on the first cycle o_ss_n is high after a frame
module p22_spi_reg_writer
  import p22_spi_reg_writer_pkg::*;
#(
  parameter int unsigned SCLK_HALF = 4,
  parameter int unsigned SS_GAP    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd,
  input  logic [23:0] payload,
  output logic        o_sclk,
  output logic        o_ss_n,
  output logic        o_mosi,
  output logic        done
);

  // One counter times both the SCLK half-periods and the inter-frame gap,
  // so it is sized for the larger of the two.
  localparam int unsigned CNT_MAX = (SCLK_HALF > SS_GAP) ? SCLK_HALF : SS_GAP;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(SS_GAP - 1);

  spi_state_e              state;
  logic [CNT_W-1:0]        cnt;
  logic [4:0]              bit_idx;
  logic [4:0]              last_idx;
  logic [SPI_MAX_BITS-1:0] shreg;

  // Frame left-justified in a 28-bit register: shifting the payload up by
  // (24 - LEN) drops every bit above LEN, so the MSB is always the next bit.
  logic [4:0]              acc_len;
  logic [4:0]              acc_shift;
  logic [23:0]             acc_data;
  logic [SPI_MAX_BITS-1:0] acc_frame;

  assign acc_len   = spi_cmd_len(cmd);
  assign acc_shift = 5'(SPI_MAX_LEN) - acc_len;
  assign acc_data  = payload << acc_shift;
  assign acc_frame = {cmd, acc_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      // Land in GAP so a receiver cut off mid-frame sees a full SS_n-high gap.
      state     <= StGap;
      cnt       <= '0;
      bit_idx   <= '0;
      last_idx  <= '0;
      shreg     <= '0;
      cmd_ready <= 1'b0;
      o_sclk    <= 1'b0;
      o_ss_n    <= 1'b1;
      o_mosi    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (cmd_valid && cmd_ready) begin
            state     <= StSetup;
            cnt       <= '0;
            bit_idx   <= '0;
            last_idx  <= acc_len + 5'd3;  // N - 1
            shreg     <= acc_frame;
            cmd_ready <= 1'b0;
            o_ss_n    <= 1'b0;
            o_mosi    <= acc_frame[SPI_MAX_BITS-1];
          end
        end

        StSetup: begin
          if (cnt == HALF_LAST) begin
            state  <= StShift;
            cnt    <= '0;
            o_sclk <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StShift: begin
          if (cnt != HALF_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (o_sclk) begin
              // Falling edge: the only point where MOSI may change.
              o_sclk <= 1'b0;
              shreg  <= {shreg[SPI_MAX_BITS-2:0], 1'b0};
              o_mosi <= (bit_idx == last_idx) ? 1'b0 : shreg[SPI_MAX_BITS-2];
            end else if (bit_idx == last_idx) begin
              state  <= StGap;
              o_ss_n <= 1'b1;
              done   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 5'd1;
              o_sclk  <= 1'b1;
            end
          end
        end

        StGap: begin
          if (cnt == GAP_LAST) begin
            state     <= StIdle;
            cnt       <= '0;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= StGap;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
